// File: rtl/aq_djpeg_idct_xbuf_if.sv
// Handshake/data bundle for the IDCT transpose buffer: row-pass writer side,
// column-pass reader side and status flags.
interface aq_djpeg_idct_xbuf_if #(
  parameter int DW      = 16,
  parameter int BANK_AW = 2
);
  logic               DataInit;
  logic               DataInEnable;
  logic [2:0]         DataInPage;
  logic [1:0]         DataInCount;
  logic               DataInIdle;
  logic [DW-1:0]      DataInA;
  logic [DW-1:0]      DataInB;
  logic               DataOutEnable;
  logic               DataOutRead;
  logic [4:0]         DataOutAddress;
  logic [DW-1:0]      DataOutA;
  logic [DW-1:0]      DataOutB;
  logic [BANK_AW:0]   Occupancy;
  logic               ErrOverflow;
  logic               ErrUnderflow;

  modport master (
    output DataInit, DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
    output DataOutRead, DataOutAddress,
    input  DataInIdle, DataOutEnable, DataOutA, DataOutB,
    input  Occupancy, ErrOverflow, ErrUnderflow
  );

  modport slave (
    input  DataInit, DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
    input  DataOutRead, DataOutAddress,
    output DataInIdle, DataOutEnable, DataOutA, DataOutB,
    output Occupancy, ErrOverflow, ErrUnderflow
  );
endinterface

// File: rtl/aq_djpeg_idct_xbuf.sv
// Ring-of-banks 8x8 transpose buffer between row and column IDCT passes.
// Define AQ_DJPEG_IDCT_XBUF_STATUS_EN to make Occupancy/ErrOverflow/ErrUnderflow live.
module aq_djpeg_idct_xbuf #(
  parameter int DW      = 16,
  parameter int BANK_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  aq_djpeg_idct_xbuf_if.slave bus
);
  localparam int NB = 1 << BANK_AW;
  localparam int AW = BANK_AW + 5;
  localparam int OW = BANK_AW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(NB);

  logic [DW-1:0]      ram0 [0:(32*NB)-1];
  logic [DW-1:0]      ram1 [0:(32*NB)-1];

  logic [BANK_AW-1:0] wr_bank_r, rd_bank_r;
  logic [OW-1:0]      occ_r, occ_nxt_s;
  logic [DW-1:0]      out_a_r, out_b_r;
  logic               full_s, out_en_s;
  logic               wr_ok_s, wr_done_s, rd_done_s;
  logic [4:0]         waddr_s;
  logic               wsel_s, rsel_s;
  logic [AW-1:0]      ram0_wa_s, ram1_wa_s, ram0_ra_s, ram1_ra_s;
  logic [DW-1:0]      ram0_wd_s, ram1_wd_s, rd_a_s, rd_b_s;
  logic [1:0]         rm_s, rc_s;

  assign full_s    = (occ_r == OCC_FULL);
  assign out_en_s  = (occ_r != {OW{1'b0}});
  assign waddr_s   = {bus.DataInPage, bus.DataInCount};
  assign wr_ok_s   = bus.DataInEnable & ~full_s & ~bus.DataInit;
  assign wr_done_s = wr_ok_s & (waddr_s == 5'd31);
  assign rd_done_s = bus.DataOutRead & out_en_s & (bus.DataOutAddress == 5'd31);

  // Sample (row,col) lives in RAM (row[2]^col[2]) at {row, col[1:0]}; a pair
  // always spans both col halves on write and both row halves on read.
  assign wsel_s    = bus.DataInPage[2];
  assign ram0_wa_s = {wr_bank_r, bus.DataInPage, wsel_s ? ~bus.DataInCount : bus.DataInCount};
  assign ram1_wa_s = {wr_bank_r, bus.DataInPage, wsel_s ? bus.DataInCount : ~bus.DataInCount};
  assign ram0_wd_s = wsel_s ? bus.DataInB : bus.DataInA;
  assign ram1_wd_s = wsel_s ? bus.DataInA : bus.DataInB;

  assign rsel_s    = bus.DataOutAddress[4];
  assign rc_s      = bus.DataOutAddress[3:2];
  assign rm_s      = bus.DataOutAddress[1:0];
  assign ram0_ra_s = {rd_bank_r, rsel_s ? {1'b1, ~rm_s} : {1'b0, rm_s}, rc_s};
  assign ram1_ra_s = {rd_bank_r, rsel_s ? {1'b0, rm_s} : {1'b1, ~rm_s}, rc_s};
  assign rd_a_s    = rsel_s ? ram1[ram1_ra_s] : ram0[ram0_ra_s];
  assign rd_b_s    = rsel_s ? ram0[ram0_ra_s] : ram1[ram1_ra_s];

  // Sample storage, one write per RAM per cycle
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      ram0[ram0_wa_s] <= ram0_wd_s;
      ram1[ram1_wa_s] <= ram1_wd_s;
    end
  end

  // Next occupancy: simultaneous complete-write and retire cancel out
  always_comb begin
    occ_nxt_s = occ_r;
    case ({wr_done_s, rd_done_s})
      2'b10:   occ_nxt_s = occ_r + OW'(1);
      2'b01:   occ_nxt_s = occ_r - OW'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Bank pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_r <= {BANK_AW{1'b0}};
      rd_bank_r <= {BANK_AW{1'b0}};
      occ_r     <= {OW{1'b0}};
    end else if (bus.DataInit) begin
      wr_bank_r <= {BANK_AW{1'b0}};
      rd_bank_r <= {BANK_AW{1'b0}};
      occ_r     <= {OW{1'b0}};
    end else begin
      if (wr_done_s) wr_bank_r <= wr_bank_r + BANK_AW'(1);
      if (rd_done_s) rd_bank_r <= rd_bank_r + BANK_AW'(1);
      occ_r <= occ_nxt_s;
    end
  end

  // Output registers follow the address every cycle; cleared by reset only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a_r <= {DW{1'b0}};
      out_b_r <= {DW{1'b0}};
    end else begin
      out_a_r <= rd_a_s;
      out_b_r <= rd_b_s;
    end
  end

  assign bus.DataInIdle    = ~full_s;
  assign bus.DataOutEnable = out_en_s;
  assign bus.DataOutA      = out_a_r;
  assign bus.DataOutB      = out_b_r;

`ifdef AQ_DJPEG_IDCT_XBUF_STATUS_EN
  logic ovf_r, unf_r;

  // Sticky drop flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (bus.DataInit) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (bus.DataInEnable & full_s);
      unf_r <= unf_r | (bus.DataOutRead & ~out_en_s);
    end
  end

  assign bus.Occupancy    = occ_r;
  assign bus.ErrOverflow  = ovf_r;
  assign bus.ErrUnderflow = unf_r;
`else
  assign bus.Occupancy    = {OW{1'b0}};
  assign bus.ErrOverflow  = 1'b0;
  assign bus.ErrUnderflow = 1'b0;
`endif
endmodule
